// File: rtl/quad_generator.sv
// -----------------------------------------------------------------------------
// quad_generator
//
// Transmit side of the rotary-encoder interface. A target position is
// accepted through a valid/ready handshake. The a/b phase lines are then
// stepped one edge at a time, one edge every STEP_CYCLES clocks, until the
// emitted position equals the target. The move takes the shortest path
// around the 8-bit ring. A distance of exactly 128 resolves to reverse.
//
// Optional feature: define QUAD_INDEX_EN to generate the registered index
// output z. z is high whenever position==0 with the phases at rest (a==b).
// When the macro is undefined, z is tied low.
// -----------------------------------------------------------------------------
module quad_generator #(
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] target,
  input  logic       target_valid,
  output logic       target_ready,
  output logic       a,
  output logic       b,
  output logic [7:0] position,
  output logic       busy,
  output logic       done,
  output logic       z
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MID    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [7:0] TIMER_RELOAD = 8'(STEP_CYCLES - 1);

  state_t     state;
  state_t     state_d;
  logic [7:0] goal;
  logic [7:0] timer;
  logic       start_q;      // goal differed from position on the previous cycle
  logic       dir_rev_q;    // direction of the count currently in flight

  logic [7:0] delta;
  logic       dir_rev;
  logic       count_edge;   // first edge of a count: moves position
  logic       second_edge;  // second edge of a count: phases back to rest
  logic       timer_reload;
  logic       timer_dec;
  logic       pulse_done;
  logic       accept;

  logic       a_d;
  logic       b_d;
  logic [7:0] position_d;

  // Shortest-path direction. A top bit set means 128..255, which is reverse.
  assign delta   = goal - position;
  assign dir_rev = delta[7];
  assign accept  = target_valid && target_ready;

  // State register.
  // NOTE: clocked processes use non-blocking assignments only. Every
  // register then samples the pre-edge values of the others, so the
  // order of the statements does not matter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and step decisions.
  // NOTE: every signal written here gets a default first. Any path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d      = state;
    count_edge   = 1'b0;
    second_edge  = 1'b0;
    timer_reload = 1'b0;
    timer_dec    = 1'b0;
    pulse_done   = 1'b0;
    unique case (state)
      IDLE: begin
        // start_q adds the cycle between acceptance and the first edge.
        if (start_q && (goal != position)) begin
          count_edge   = 1'b1;
          timer_reload = 1'b1;
          state_d      = MID;
        end
      end
      MID: begin
        if (timer == 8'd0) begin
          second_edge  = 1'b1;
          timer_reload = 1'b1;
          state_d      = SETTLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      SETTLE: begin
        if (timer == 8'd0) begin
          if (goal != position) begin
            count_edge   = 1'b1;
            timer_reload = 1'b1;
            state_d      = MID;
          end else begin
            pulse_done = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next phase and position values.
  // Forward: the count edge toggles a and the second edge toggles b.
  // Reverse: the roles of a and b swap.
  always_comb begin
    a_d        = a;
    b_d        = b;
    position_d = position;
    if (count_edge) begin
      if (!dir_rev) begin
        a_d        = ~a;
        position_d = position + 8'd1;
      end else begin
        b_d        = ~b;
        position_d = position - 8'd1;
      end
    end else if (second_edge) begin
      if (!dir_rev_q) begin
        b_d = ~b;
      end else begin
        a_d = ~a;
      end
    end
  end

  // Datapath registers: goal, timer, phases, position and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      goal      <= 8'd0;
      timer     <= 8'd0;
      start_q   <= 1'b0;
      dir_rev_q <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      position  <= 8'd0;
      done      <= 1'b0;
    end else begin
      if (accept) begin
        goal <= target;
      end
      if (timer_reload) begin
        timer <= TIMER_RELOAD;
      end else if (timer_dec) begin
        timer <= timer - 8'd1;
      end
      if (count_edge) begin
        dir_rev_q <= dir_rev;
      end
      start_q  <= (goal != position);
      a        <= a_d;
      b        <= b_d;
      position <= position_d;
      done     <= pulse_done;
    end
  end

  // Status outputs derived from the registered state.
  always_comb begin
    busy         = (state != IDLE);
    target_ready = (state == IDLE) && (goal == position);
  end

`ifdef QUAD_INDEX_EN
  // Index mark: registered from the same next values as a, b and position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z <= 1'b0;
    end else begin
      z <= (position_d == 8'd0) && (a_d == b_d);
    end
  end
`else
  assign z = 1'b0;
`endif

endmodule
